mem_arbiter: RTL and testbench

- Shares the single RAM port between the instruction fetch path (iREN/iaddr) and the memory stage's data path (dREN/dWEN/daddr/dstore).
- Holds off the losing requester with iwait/dwait; the pipeline latches on ihit/dhit, which are derived from these waits.
- Data has priority. An anti-starvation counter forces an instruction grant after a bounded run of data grants.
- A timeout and RAM-error detector sets a sticky bus error flag.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter_sat_counter.sv | 28 ++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the RAM-port arbiter: word type, RAM handshake states and
// the arbiter's own state encoding.
package mem_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DGNT = 2'd1,
    IGNT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; flags when it sits at MAX.
module arb_sat_counter #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned W = (MAX < 2) ? 1 : $clog2(MAX + 1);

  logic [W-1:0] cnt_q;

  assign at_max = (cnt_q == W'(MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !at_max) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access: data has
// priority, bounded by an anti-starvation count; timeout/ERROR set a sticky bus_err.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned CNT_W        = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        bus_err
);

  arb_state_t       state_q;
  logic [CNT_W-1:0] tmo_q;
  logic             bus_err_q;

  ramstate_t rs;
  logic      dreq;
  logic      greq;
  logic      dcomp;
  logic      icomp;
  logic      starved;

  assign rs      = ramstate_t'(ramstate);
  assign dreq    = dREN | dWEN;
  assign greq    = (state_q == DGNT) ? dreq : iREN;
  assign dcomp   = (state_q == DGNT) && dreq && (rs == ACCESS);
  assign icomp   = (state_q == IGNT) && iREN && (rs == ACCESS);
  assign bus_err = bus_err_q;

  arb_sat_counter #(
    .MAX (STARVE_LIMIT)
  ) u_starve (
    .clk    (CLK),
    .rst    (RST),
    .inc    (dcomp && iREN),
    .clr    (icomp),
    .at_max (starved)
  );

  // Completion outputs are combinational so the pipeline can latch in the
  // same cycle the RAM reports ACCESS.
  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state_q)
      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (dcomp) begin
          dwait = 1'b0;
          dload = ramload;
        end
      end
      IGNT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (icomp) begin
          iwait = 1'b0;
          iload = ramload;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      tmo_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (dreq && !(iREN && starved)) begin
            state_q <= DGNT;
          end else if (iREN) begin
            state_q <= IGNT;
          end
        end
        DGNT, IGNT: begin
          if (!greq || rs == ACCESS) begin
            state_q <= IDLE;
            tmo_q   <= '0;
          end else if (rs == ERROR || tmo_q == CNT_W'(TIMEOUT)) begin
            state_q   <= IDLE;
            tmo_q     <= '0;
            bus_err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tmo_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus randomized traffic, every cycle checked against a
// transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int unsigned LIM = 4;
  localparam int unsigned TMO = 8;

  localparam logic [1:0] RS_FREE = 2'd0;
  localparam logic [1:0] RS_BUSY = 2'd1;
  localparam logic [1:0] RS_ACC  = 2'd2;
  localparam logic [1:0] RS_ERR  = 2'd3;

  logic        CLK = 1'b0;
  logic        RST, iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, bus_err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  always #5 CLK = ~CLK;

  mem_arbiter #(
    .STARVE_LIMIT (LIM),
    .TIMEOUT      (TMO),
    .CNT_W        (8)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .bus_err  (bus_err)
  );

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: who owns the port (0 none, 1 data, 2 instr), grant cycles waited,
  // data completions in a row while instr pending, sticky error.
  int unsigned m_own    = 0;
  int unsigned m_waited = 0;
  int unsigned m_streak = 0;
  bit          m_err    = 1'b0;

  int unsigned n_icomp, n_dcomp;
  logic [31:0] seq;

  task automatic step(input logic rst, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dw, input logic [31:0] da,
                      input logic [31:0] ds, input logic [1:0] rs, input logic [31:0] rl);
    logic        req, done;
    logic        e_iw, e_dw, e_rr, e_rw;
    logic [31:0] e_il, e_dl, e_ra, e_rd;
    @(negedge CLK);
    RST = rst; iREN = ir; iaddr = ia; dREN = dr; dWEN = dw;
    daddr = da; dstore = ds; ramstate = rs; ramload = rl;
    #2;
    req  = (m_own == 1) ? (dr | dw) : ir;
    done = (m_own != 0) && req && (rs == RS_ACC);
    e_iw = 1'b1; e_dw = 1'b1; e_rr = 1'b0; e_rw = 1'b0;
    e_il = '0; e_dl = '0; e_ra = '0; e_rd = '0;
    if (m_own == 1) begin
      e_ra = da; e_rd = ds; e_rw = dw; e_rr = dr & ~dw;
      if (done) begin e_dw = 1'b0; e_dl = rl; end
    end else if (m_own == 2) begin
      e_ra = ia; e_rr = 1'b1;
      if (done) begin e_iw = 1'b0; e_il = rl; end
    end
    check_eq("iwait", 32'(iwait), 32'(e_iw));
    check_eq("dwait", 32'(dwait), 32'(e_dw));
    check_eq("iload", iload, e_il);
    check_eq("dload", dload, e_dl);
    check_eq("ramREN", 32'(ramREN), 32'(e_rr));
    check_eq("ramWEN", 32'(ramWEN), 32'(e_rw));
    check_eq("ramaddr", ramaddr, e_ra);
    check_eq("ramstore", ramstore, e_rd);
    check_eq("bus_err", 32'(bus_err), 32'(m_err));
    if (!iwait) begin n_icomp++; seq = (seq << 2) | 32'd2; end
    if (!dwait) begin n_dcomp++; seq = (seq << 2) | 32'd1; end
    if (rst) begin
      m_own = 0; m_waited = 0; m_streak = 0; m_err = 1'b0;
    end else if (m_own == 0) begin
      m_waited = 0;
      if ((dr | dw) && !(ir && m_streak == LIM)) m_own = 1;
      else if (ir) m_own = 2;
    end else if (!req) begin
      m_own = 0;
    end else if (done) begin
      if (m_own == 1 && ir && m_streak < LIM) m_streak++;
      if (m_own == 2) m_streak = 0;
      m_own = 0;
    end else if (rs == RS_ERR || m_waited == TMO) begin
      m_err = 1'b1;
      m_own = 0;
    end else begin
      m_waited++;
    end
    if (m_own == 0) m_waited = 0;
  endtask

  task automatic idle_reset();
    step(1'b1, 0, '0, 0, 0, '0, '0, RS_FREE, '0);
    n_icomp = 0; n_dcomp = 0; seq = '0;
  endtask

  logic r_ir, r_dr, r_dw;
  logic [1:0] r_rs;
  int unsigned pick;

  initial begin
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = RS_FREE;
    idle_reset();
    step(1'b0, 0, '0, 0, 0, '0, '0, RS_FREE, '0);

    // Instruction fetch with one BUSY cycle before ACCESS.
    idle_reset();
    step(0, 1, 32'h100, 0, 0, '0, '0, RS_FREE, '0);
    step(0, 1, 32'h100, 0, 0, '0, '0, RS_BUSY, '0);
    step(0, 1, 32'h100, 0, 0, '0, '0, RS_ACC, 32'hDEADBEEF);
    step(0, 0, 32'h100, 0, 0, '0, '0, RS_FREE, '0);
    step(0, 0, 32'h100, 0, 0, '0, '0, RS_ACC, 32'h1);
    check_eq("s1_icomp", n_icomp, 1);

    // Simultaneous instr + data write: data first, then instruction.
    idle_reset();
    step(0, 1, 32'h104, 0, 1, 32'h200, 32'h5A5A5A5A, RS_FREE, '0);
    step(0, 1, 32'h104, 0, 1, 32'h200, 32'h5A5A5A5A, RS_ACC, 32'h77);
    step(0, 1, 32'h104, 0, 0, 32'h200, 32'h5A5A5A5A, RS_FREE, '0);
    step(0, 1, 32'h104, 0, 0, 32'h200, 32'h5A5A5A5A, RS_ACC, 32'h12345678);
    check_eq("s2_order", seq, 32'h6);

    // Starvation: four data completions, one instruction, then data again.
    idle_reset();
    for (int i = 0; i < 12; i++)
      step(0, 1, 32'h300, 1, 0, 32'h400 + 32'(i), '0, RS_ACC, 32'(i));
    check_eq("s3_order", seq, 32'h559);

    // Timeout with RAM stuck BUSY; bus_err survives a later good transfer.
    idle_reset();
    for (int i = 0; i < 12; i++)
      step(0, 0, '0, 1, 0, 32'h500, '0, RS_BUSY, '0);
    check_eq("s4_err", 32'(bus_err), 1);
    check_eq("s4_nodone", n_dcomp, 0);
    step(0, 0, '0, 0, 0, 32'h500, '0, RS_FREE, '0);
    step(0, 0, '0, 1, 0, 32'h504, '0, RS_FREE, '0);
    step(0, 0, '0, 1, 0, 32'h504, '0, RS_ACC, 32'hCAFE);
    step(0, 0, '0, 0, 0, 32'h504, '0, RS_FREE, '0);
    check_eq("s4_sticky", 32'(bus_err), 1);
    check_eq("s4_done", n_dcomp, 1);

    // ERROR during instruction grant, then retry succeeds.
    idle_reset();
    step(0, 1, 32'h600, 0, 0, '0, '0, RS_FREE, '0);
    step(0, 1, 32'h600, 0, 0, '0, '0, RS_ERR, '0);
    step(0, 1, 32'h600, 0, 0, '0, '0, RS_FREE, '0);
    step(0, 1, 32'h600, 0, 0, '0, '0, RS_ACC, 32'hBEEF0001);
    check_eq("s5_icomp", n_icomp, 1);

    // Reset mid data grant, then request withdrawn mid grant.
    idle_reset();
    step(0, 0, '0, 1, 0, 32'h700, '0, RS_FREE, '0);
    step(0, 0, '0, 1, 0, 32'h700, '0, RS_BUSY, '0);
    step(1, 0, '0, 1, 0, 32'h700, '0, RS_BUSY, '0);
    step(0, 0, '0, 0, 0, 32'h700, '0, RS_BUSY, '0);
    step(0, 0, '0, 1, 0, 32'h704, '0, RS_FREE, '0);
    step(0, 0, '0, 0, 0, 32'h704, '0, RS_ACC, 32'h99);
    step(0, 0, '0, 0, 0, 32'h704, '0, RS_ACC, 32'h99);
    check_eq("s6_nodone", n_dcomp, 0);

    // Randomized traffic with slowly changing requests.
    r_ir = 0; r_dr = 0; r_dw = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(99) < 15) r_ir = ~r_ir;
      if ($urandom_range(99) < 15) r_dr = ~r_dr;
      if ($urandom_range(99) < 10) r_dw = ~r_dw;
      pick = $urandom_range(99);
      r_rs = (pick < 45) ? RS_ACC : (pick < 85) ? RS_BUSY : (pick < 95) ? RS_FREE : RS_ERR;
      step(($urandom_range(99) < 2), r_ir, $urandom, r_dr, r_dw, $urandom, $urandom,
           r_rs, $urandom);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
